// File: rtl/mem_ctrl_pkg.sv
// Shared load/store control types and store-lane helpers for the MEM stage.
// Holds the access length/sign encodings and the access FSM state type.
package mem_ctrl;

  typedef enum logic [1:0] {
    a_byte = 2'd0,
    a_half = 2'd1,
    a_word = 2'd2
  } length_t;

  typedef enum logic {
    t_unsigned = 1'b0,
    t_signed   = 1'b1
  } sign_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } mau_state_t;

  function automatic logic [3:0] store_mask(input length_t len, input logic [1:0] off);
    logic [3:0] m;
    case (len)
      a_byte:  m = 4'b0001 << off;
      a_half:  m = 4'b0011 << {off[1], 1'b0};
      default: m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] store_lanes(input length_t len, input logic [31:0] d);
    logic [31:0] r;
    case (len)
      a_byte:  r = {4{d[7:0]}};
      a_half:  r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic misaligned(input length_t len, input logic [1:0] off);
    logic bad;
    case (len)
      a_byte:  bad = 1'b0;
      a_half:  bad = off[0];
      default: bad = (off != 2'b00);
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/mem_access_unit_load_extract.sv
// Picks the addressed byte/half out of a memory word and sign/zero-extends it.
// Purely combinational; word loads pass through untouched.
module load_extract
  import mem_ctrl::*;
(
  input  logic [31:0] dmem_rdata,
  input  logic [1:0]  offset,
  input  length_t     length,
  input  sign_t       sign,
  output logic [31:0] data
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;
  logic        ext;

  always_comb begin
    byte_lane = dmem_rdata[{offset, 3'b000} +: 8];
    half_lane = dmem_rdata[{offset[1], 4'b0000} +: 16];
    ext       = 1'b0;
    data      = dmem_rdata;
    case (length)
      a_byte: begin
        ext  = (sign == t_signed) & byte_lane[7];
        data = {{24{ext}}, byte_lane};
      end
      a_half: begin
        ext  = (sign == t_signed) & half_lane[15];
        data = {{16{ext}}, half_lane};
      end
      default: data = dmem_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_unit.sv
// MEM-stage load/store engine: word-aligned dmem request, resp handshake, extended load data.
// Optional MISALIGN_TRAP_EN adds misalign_err and skips the request for misaligned half/word.
module mem_access_unit
  import mem_ctrl::*;
#(
  parameter int MAX_WAIT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_read,
  input  logic        mem_write,
  input  length_t     access_length,
  input  sign_t       access_sign,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        stall,
  output logic [31:0] rdata,
  output logic        rdata_valid,
  output logic        timeout,
  output logic [31:0] dmem_address,
  output logic        dmem_read,
  output logic        dmem_write,
  output logic [3:0]  dmem_wmask,
  output logic [31:0] dmem_wdata,
  input  logic [31:0] dmem_rdata,
  input  logic        dmem_resp
`ifdef MISALIGN_TRAP_EN
  ,
  output logic        misalign_err
`endif
);

  localparam int CW = (MAX_WAIT > 2) ? $clog2(MAX_WAIT) : 1;

  mau_state_t    state, state_nxt;
  logic [1:0]    offset_q;
  length_t       length_q;
  sign_t         sign_q;
  logic          is_load_q;
  logic          misalign_q;
  logic [CW-1:0] wait_cnt;
  logic [31:0]   ext_word;
  logic          req;
  logic          bad;

  assign req = mem_read | mem_write;

`ifdef MISALIGN_TRAP_EN
  assign bad          = misaligned(access_length, addr[1:0]);
  assign misalign_err = (state == DONE) & misalign_q;
`else
  assign bad = 1'b0;
`endif

  load_extract u_load_extract (
    .dmem_rdata (dmem_rdata),
    .offset     (offset_q),
    .length     (length_q),
    .sign       (sign_q),
    .data       (ext_word)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    stall       = 1'b0;
    rdata_valid = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          stall     = 1'b1;
          state_nxt = bad ? DONE : BUSY;
        end
      end
      BUSY: begin
        stall = 1'b1;
        if (dmem_resp) state_nxt = DONE;
      end
      DONE: begin
        rdata_valid = is_load_q & ~misalign_q;
        state_nxt   = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request fields are registered at IDLE exit and held unchanged until resp.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      offset_q     <= 2'b00;
      length_q     <= a_byte;
      sign_q       <= t_unsigned;
      is_load_q    <= 1'b0;
      misalign_q   <= 1'b0;
      wait_cnt     <= '0;
      timeout      <= 1'b0;
      rdata        <= 32'h0;
      dmem_address <= 32'h0;
      dmem_read    <= 1'b0;
      dmem_write   <= 1'b0;
      dmem_wmask   <= 4'h0;
      dmem_wdata   <= 32'h0;
    end else begin
      case (state)
        IDLE: begin
          if (req) begin
            offset_q   <= addr[1:0];
            length_q   <= access_length;
            sign_q     <= access_sign;
            is_load_q  <= ~mem_write;
            misalign_q <= bad;
            wait_cnt   <= '0;
            if (!bad) begin
              dmem_address <= {addr[31:2], 2'b00};
              dmem_read    <= ~mem_write;
              dmem_write   <= mem_write;
              dmem_wmask   <= mem_write ? store_mask(access_length, addr[1:0]) : 4'h0;
              dmem_wdata   <= mem_write ? store_lanes(access_length, wdata) : 32'h0;
            end
          end
        end
        BUSY: begin
          if (dmem_resp) begin
            dmem_read  <= 1'b0;
            dmem_write <= 1'b0;
            if (is_load_q) rdata <= ext_word;
          end else if (wait_cnt == CW'(MAX_WAIT - 1)) begin
            // Counter parks here; the request stays up so a late resp still completes.
            timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Table-driven bench for mem_access_unit with a load-data scoreboard queue.
// Multi-cycle corners (timeout, reset mid-access, misalign trap) are hand-written sequences.
module tb_mem_access_unit;
  import mem_ctrl::*;

  localparam int MW = 16;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        mem_read = 1'b0, mem_write = 1'b0;
  length_t     access_length = a_byte;
  sign_t       access_sign = t_unsigned;
  logic [31:0] addr = 32'h0, wdata = 32'h0;
  logic        stall, rdata_valid, timeout;
  logic [31:0] rdata, dmem_address, dmem_wdata;
  logic        dmem_read, dmem_write;
  logic [3:0]  dmem_wmask;
  logic [31:0] dmem_rdata = 32'h0;
  logic        dmem_resp = 1'b0;
`ifdef MISALIGN_TRAP_EN
  logic        misalign_err;
`endif

  mem_access_unit #(.MAX_WAIT(MW)) dut (
    .clk(clk), .rst(rst), .mem_read(mem_read), .mem_write(mem_write),
    .access_length(access_length), .access_sign(access_sign),
    .addr(addr), .wdata(wdata), .stall(stall), .rdata(rdata),
    .rdata_valid(rdata_valid), .timeout(timeout),
    .dmem_address(dmem_address), .dmem_read(dmem_read), .dmem_write(dmem_write),
    .dmem_wmask(dmem_wmask), .dmem_wdata(dmem_wdata),
    .dmem_rdata(dmem_rdata), .dmem_resp(dmem_resp)
`ifdef MISALIGN_TRAP_EN
    , .misalign_err(misalign_err)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          rd;
    bit          wr;
    length_t     len;
    sign_t       sgn;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] mem;
    int          delay;
    logic [31:0] exp_addr;
    logic [3:0]  exp_mask;
    logic [31:0] exp_wdata;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t        vecs[$];
  logic [31:0] exp_q[$];
  logic [31:0] last_rdata = 32'h0;
  int          n_tests = 0;
  int          n_fail  = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input bit rd, input bit wr, input length_t len, input sign_t sgn,
                              input logic [31:0] a, input logic [31:0] wd, input logic [31:0] mem,
                              input int delay, input logic [31:0] ea, input logic [3:0] em,
                              input logic [31:0] ew, input logic [31:0] er);
    vec_t v;
    v.rd = rd; v.wr = wr; v.len = len; v.sgn = sgn; v.addr = a; v.wdata = wd; v.mem = mem;
    v.delay = delay; v.exp_addr = ea; v.exp_mask = em; v.exp_wdata = ew; v.exp_rdata = er;
    return v;
  endfunction

  // Scoreboard: every rdata_valid strobe must match the oldest pending load.
  always @(negedge clk) begin
    if (rst && rdata_valid) begin
      if (exp_q.size() == 0) begin
        n_tests++;
        n_fail++;
        $display("FAIL unexpected_rdata_valid: got rdata %h, expected no strobe", rdata);
      end else begin
        check("sb_rdata", rdata, exp_q.pop_front());
      end
    end
  end

  task automatic run_access(input vec_t v);
    int busy;
    int stalls;
    bit done;
    bit is_ld;
    is_ld = v.rd && !v.wr;
    @(negedge clk);
    mem_read = v.rd; mem_write = v.wr; access_length = v.len; access_sign = v.sgn;
    addr = v.addr; wdata = v.wdata;
    #1;
    check("idle_stall", stall, 1);
    if (is_ld) exp_q.push_back(v.exp_rdata);
    stalls = 1; busy = 0; done = 0;
    for (int c = 0; c < MW + 40 && !done; c++) begin
      @(negedge clk);
      dmem_resp = 1'b0;
      if (stall) begin
        busy++;
        stalls++;
        if (busy == 1) begin
          check("dmem_address", dmem_address, v.exp_addr);
          check("dmem_read", dmem_read, is_ld);
          check("dmem_write", dmem_write, v.wr);
          check("dmem_wmask", dmem_wmask, v.exp_mask);
          if (v.wr) check("dmem_wdata", dmem_wdata, v.exp_wdata);
        end
        if (busy == MW) check("timeout_early", timeout, 0);
        if (busy == MW + 1) begin
          check("timeout_set", timeout, 1);
          check("read_held_after_timeout", dmem_read, 1);
        end
        if (busy == v.delay) begin
          check("req_held_at_resp", {dmem_read, dmem_write}, {is_ld, v.wr});
          dmem_resp  = 1'b1;
          dmem_rdata = v.mem;
        end
      end else begin
        done = 1;
        check("stall_cycles", stalls, v.delay + 1);
        check("req_dropped", {dmem_read, dmem_write}, 0);
        check("rdata_valid_done", rdata_valid, is_ld);
        if (is_ld) last_rdata = v.exp_rdata;
        else check("rdata_hold", rdata, last_rdata);
      end
    end
    if (!done) check("access_completes", 0, 1);
    mem_read = 1'b0; mem_write = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected bench end");
    $fatal(1, "watchdog");
  end

  initial begin
    //       rd wr len     sign        addr          wdata         mem           d  exp_addr      mask     exp_wdata     exp_rdata
    vecs.push_back(mk(0, 1, a_byte, t_unsigned, 32'h0000_1003, 32'h1234_56AB, 32'h0, 1, 32'h0000_1000, 4'b1000, 32'hABAB_ABAB, 32'h0));
    vecs.push_back(mk(1, 0, a_half, t_signed,   32'h0000_2002, 32'h0, 32'h8001_1234, 1, 32'h0000_2000, 4'b0000, 32'h0, 32'hFFFF_8001));
    vecs.push_back(mk(1, 0, a_half, t_unsigned, 32'h0000_2002, 32'h0, 32'h8001_1234, 2, 32'h0000_2000, 4'b0000, 32'h0, 32'h0000_8001));
    vecs.push_back(mk(1, 0, a_byte, t_unsigned, 32'h0000_3001, 32'h0, 32'h0000_F500, 5, 32'h0000_3000, 4'b0000, 32'h0, 32'h0000_00F5));
    vecs.push_back(mk(0, 1, a_half, t_unsigned, 32'h0000_5002, 32'hAAAA_BEEF, 32'h0, 1, 32'h0000_5000, 4'b1100, 32'hBEEF_BEEF, 32'h0));
    vecs.push_back(mk(0, 1, a_word, t_unsigned, 32'h0000_6000, 32'hDEAD_BEEF, 32'h0, 3, 32'h0000_6000, 4'b1111, 32'hDEAD_BEEF, 32'h0));
    vecs.push_back(mk(1, 0, a_byte, t_signed,   32'h0000_7003, 32'h0, 32'h80FF_0000, 1, 32'h0000_7000, 4'b0000, 32'h0, 32'hFFFF_FF80));
    vecs.push_back(mk(1, 0, a_word, t_signed,   32'h0000_8000, 32'h0, 32'h1357_9BDF, 2, 32'h0000_8000, 4'b0000, 32'h0, 32'h1357_9BDF));
    vecs.push_back(mk(1, 1, a_byte, t_signed,   32'h0000_9000, 32'h0000_0055, 32'hFFFF_FFFF, 1, 32'h0000_9000, 4'b0001, 32'h5555_5555, 32'h0));
    vecs.push_back(mk(1, 0, a_byte, t_signed,   32'h0000_A000, 32'h0, 32'hFFFF_FF7F, 1, 32'h0000_A000, 4'b0000, 32'h0, 32'h0000_007F));
    vecs.push_back(mk(1, 0, a_half, t_signed,   32'h0000_B000, 32'h0, 32'h1234_7FFF, 4, 32'h0000_B000, 4'b0000, 32'h0, 32'h0000_7FFF));
`ifndef MISALIGN_TRAP_EN
    vecs.push_back(mk(0, 1, a_half, t_unsigned, 32'h0000_C001, 32'h0000_1357, 32'h0, 1, 32'h0000_C000, 4'b0011, 32'h1357_1357, 32'h0));
    vecs.push_back(mk(1, 0, a_word, t_unsigned, 32'h0000_4002, 32'h0, 32'hCAFE_F00D, 2, 32'h0000_4000, 4'b0000, 32'h0, 32'hCAFE_F00D));
`endif

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_stall", stall, 0);
    check("rst_dmem_req", {dmem_read, dmem_write}, 0);
    check("rst_wmask", dmem_wmask, 0);
    check("rst_address", dmem_address, 0);
    check("rst_timeout", timeout, 0);
    check("rst_rdata_valid", rdata_valid, 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b1;

    foreach (vecs[i]) run_access(vecs[i]);

    // Timeout: resp withheld past MAX_WAIT, late resp still completes, flag sticks
    run_access(mk(1, 0, a_word, t_unsigned, 32'h0000_D000, 32'h0, 32'h0BAD_F00D, MW + 2, 32'h0000_D000, 4'b0000, 32'h0, 32'h0BAD_F00D));
    run_access(mk(1, 0, a_byte, t_unsigned, 32'h0000_E002, 32'h0, 32'h0042_0000, 1, 32'h0000_E000, 4'b0000, 32'h0, 32'h0000_0042));
    check("timeout_sticky", timeout, 1);

    // Reset asserted mid-BUSY: request drops without a clock edge, late resp ignored
    @(negedge clk);
    mem_read = 1'b1; access_length = a_word; addr = 32'h0000_F000;
    @(negedge clk);
    @(negedge clk);
    check("busy_before_rst", dmem_read, 1);
    #2 rst = 1'b0;
    mem_read = 1'b0;
    #1;
    check("rst_async_read_drop", dmem_read, 0);
    check("rst_async_timeout_clear", timeout, 0);
    @(negedge clk);
    rst = 1'b1;
    dmem_resp = 1'b1; dmem_rdata = 32'h7777_7777;
    @(negedge clk);
    dmem_resp = 1'b0;
    check("post_rst_idle_stall", stall, 0);
    check("post_rst_no_valid", rdata_valid, 0);
    @(negedge clk);
    check("post_rst_no_valid2", rdata_valid, 0);
    check("post_rst_read", dmem_read, 0);

`ifdef MISALIGN_TRAP_EN
    // Misaligned word load traps in one stall cycle with no memory request
    @(negedge clk);
    mem_read = 1'b1; access_length = a_word; access_sign = t_unsigned; addr = 32'h0000_4002;
    #1;
    check("mis_stall_idle", stall, 1);
    check("mis_err_idle", misalign_err, 0);
    @(negedge clk);
    check("mis_stall_done", stall, 0);
    check("mis_err_done", misalign_err, 1);
    check("mis_no_valid", rdata_valid, 0);
    check("mis_no_read", dmem_read, 0);
    check("mis_rdata_hold", rdata, 0);
    mem_read = 1'b0;
    @(negedge clk);
    check("mis_err_clear", misalign_err, 0);
    check("mis_no_read2", dmem_read, 0);
`endif

    repeat (2) @(negedge clk);
    check("sb_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
